// File: rtl/lcd_digit_driver.sv
// HD44780 16x2 character LCD driver: power-up init, then renders 32 hex digits
// (digits 0-15 on line 1, 16-31 on line 2) each time a new digit vector arrives.
module lcd_digit_driver #(
    parameter int PWRUP_CYC = 750000,
    parameter int EN_CYC    = 16,
    parameter int CMD_CYC   = 2000,
    parameter int CLR_CYC   = 82000
) (
    input  logic         s_axi_aclk,
    input  logic         reset,
    input  logic [127:0] digits,
    input  logic         digits_valid,
    output logic [7:0]   LCD_DATA,
    output logic         LCD_RS,
    output logic         LCD_EN,
    output logic         LCD_RW,
    output logic         LCD_ON,
    output logic         busy,
    output logic         frame_done
);

    localparam int MAX_A   = (PWRUP_CYC > CLR_CYC) ? PWRUP_CYC : CLR_CYC;
    localparam int MAX_B   = (MAX_A > CMD_CYC) ? MAX_A : CMD_CYC;
    localparam int MAX_CYC = (MAX_B > EN_CYC) ? MAX_B : EN_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] PWRUP_LAST = CW'(PWRUP_CYC - 1);
    localparam logic [CW-1:0] EN_LAST    = CW'(EN_CYC - 1);
    localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_CYC - 1);
    localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_CYC - 1);

    typedef enum logic [2:0] {
        S_PWRUP, S_INIT, S_IDLE, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2
    } state_e;

    typedef enum logic [1:0] {
        W_SET, W_ENH, W_WAIT
    } wr_e;

    state_e         state_q, state_d;
    wr_e            wr_q, wr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     idx_q, idx_d;
    logic [127:0]   shadow_q, shadow_d;
    logic [127:0]   frame_q, frame_d;
    logic           pending_q, pending_d;
    logic [7:0]     data_q, data_d;
    logic           rs_q, rs_d;
    logic           en_q, en_d;
    logic           on_q;
    logic           busy_q;

    logic           write_done;
    logic           start_frame;
    logic           go_idle;
    logic [3:0]     idx_next;
    logic [CW-1:0]  wait_last;

    function automatic logic [7:0] hex_char(input logic [3:0] v);
        if (v < 4'd10) begin
            return 8'h30 + {4'h0, v};
        end
        return 8'h37 + {4'h0, v};
    endfunction

    function automatic logic [3:0] digit_at(input logic [127:0] f, input logic [4:0] r);
        return f[{r, 2'b00} +: 4];
    endfunction

    function automatic logic [7:0] init_cmd(input logic [3:0] i);
        case (i)
            4'd0, 4'd1, 4'd2: return 8'h38;
            4'd3:             return 8'h0C;
            4'd4:             return 8'h01;
            4'd5:             return 8'h06;
            default:          return 8'h00;
        endcase
    endfunction

    // The clear command needs a much longer settle time than anything else.
    assign wait_last = (!rs_q && data_q == 8'h01) ? CLR_LAST : CMD_LAST;
    assign idx_next  = idx_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        frame_d     = frame_q;
        data_d      = data_q;
        rs_d        = rs_q;
        shadow_d    = digits_valid ? digits : shadow_q;
        pending_d   = pending_q | digits_valid;
        write_done  = 1'b0;
        start_frame = 1'b0;
        go_idle     = 1'b0;

        if (state_q != S_PWRUP && state_q != S_IDLE) begin
            case (wr_q)
                W_SET: begin
                    wr_d  = W_ENH;
                    cnt_d = '0;
                end
                W_ENH: begin
                    if (cnt_q == EN_LAST) begin
                        wr_d  = W_WAIT;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (cnt_q == wait_last) begin
                        write_done = 1'b1;
                        wr_d       = W_SET;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end

        case (state_q)
            S_PWRUP: begin
                if (cnt_q == PWRUP_LAST) begin
                    state_d = S_INIT;
                    idx_d   = 4'd0;
                    data_d  = init_cmd(4'd0);
                    rs_d    = 1'b0;
                    wr_d    = W_SET;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_INIT: begin
                if (write_done) begin
                    if (idx_q == 4'd5) begin
                        start_frame = pending_d;
                        go_idle     = !pending_d;
                    end else begin
                        idx_d  = idx_next;
                        data_d = init_cmd(idx_next);
                    end
                end
            end
            S_IDLE: begin
                start_frame = pending_q;
            end
            S_ADDR1: begin
                if (write_done) begin
                    state_d = S_LINE1;
                    idx_d   = 4'd0;
                    data_d  = hex_char(digit_at(frame_q, 5'd0));
                    rs_d    = 1'b1;
                end
            end
            S_LINE1: begin
                if (write_done) begin
                    if (idx_q == 4'd15) begin
                        state_d = S_ADDR2;
                        data_d  = 8'hC0;
                        rs_d    = 1'b0;
                    end else begin
                        idx_d  = idx_next;
                        data_d = hex_char(digit_at(frame_q, {1'b0, idx_next}));
                    end
                end
            end
            S_ADDR2: begin
                if (write_done) begin
                    state_d = S_LINE2;
                    idx_d   = 4'd0;
                    data_d  = hex_char(digit_at(frame_q, 5'd16));
                    rs_d    = 1'b1;
                end
            end
            default: begin
                if (write_done) begin
                    if (idx_q == 4'd15) begin
                        start_frame = pending_d;
                        go_idle     = !pending_d;
                    end else begin
                        idx_d  = idx_next;
                        data_d = hex_char(digit_at(frame_q, {1'b1, idx_next}));
                    end
                end
            end
        endcase

        // A strobe landing on the frame-start cycle goes straight into the new frame.
        if (start_frame) begin
            state_d   = S_ADDR1;
            frame_d   = shadow_d;
            pending_d = 1'b0;
            data_d    = 8'h80;
            rs_d      = 1'b0;
            wr_d      = W_SET;
            cnt_d     = '0;
        end
        if (go_idle) begin
            state_d = S_IDLE;
            wr_d    = W_SET;
            cnt_d   = '0;
        end

        en_d = (wr_d == W_ENH);
    end

    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            state_q   <= S_PWRUP;
            wr_q      <= W_SET;
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            frame_q   <= '0;
            pending_q <= 1'b0;
            data_q    <= '0;
            rs_q      <= 1'b0;
            en_q      <= 1'b0;
            on_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            frame_q   <= frame_d;
            pending_q <= pending_d;
            data_q    <= data_d;
            rs_q      <= rs_d;
            en_q      <= en_d;
            on_q      <= 1'b1;
            busy_q    <= (state_d != S_IDLE);
        end
    end

    assign LCD_DATA   = data_q;
    assign LCD_RS     = rs_q;
    assign LCD_EN     = en_q;
    assign LCD_RW     = 1'b0;
    assign LCD_ON     = on_q;
    assign busy       = busy_q;
    assign frame_done = (state_q == S_LINE2) && (idx_q == 4'd15) && write_done;

endmodule

// File: tb/tb_lcd_digit_driver.sv
// Self-checking bench for lcd_digit_driver: a bus monitor logs every EN pulse and
// the log is compared against byte sequences built from the display rules.
module tb_lcd_digit_driver;

    localparam int PWRUP_CYC = 20;
    localparam int EN_CYC    = 4;
    localparam int CMD_CYC   = 8;
    localparam int CLR_CYC   = 30;
    localparam int WR_CYC    = 1 + EN_CYC + CMD_CYC;

    logic         s_axi_aclk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] digits = '0;
    logic         digits_valid = 1'b0;
    logic [7:0]   LCD_DATA;
    logic         LCD_RS, LCD_EN, LCD_RW, LCD_ON, busy, frame_done;

    typedef struct {
        logic [3:0] v;
        logic [7:0] ch;
    } hexVec_t;

    hexVec_t     hexTable[16];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          idleCount = 0;
    int          fdCount = 0;
    int          fdCyc = 0;
    int          strobeCyc = 0;
    logic [8:0]  wrLog[$];
    logic [8:0]  wrHold[$];
    int          wrCyc[$];
    int          wrLen[$];
    logic [8:0]  expQ[$];

    lcd_digit_driver #(
        .PWRUP_CYC(PWRUP_CYC),
        .EN_CYC(EN_CYC),
        .CMD_CYC(CMD_CYC),
        .CLR_CYC(CLR_CYC)
    ) dut (
        .s_axi_aclk(s_axi_aclk),
        .reset(reset),
        .digits(digits),
        .digits_valid(digits_valid),
        .LCD_DATA(LCD_DATA),
        .LCD_RS(LCD_RS),
        .LCD_EN(LCD_EN),
        .LCD_RW(LCD_RW),
        .LCD_ON(LCD_ON),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 s_axi_aclk = ~s_axi_aclk;

    // Cycle number relative to reset release: edge 1 is the first edge with reset low.
    always @(posedge s_axi_aclk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Bus monitor: one log entry per EN pulse, recorded when EN falls.
    initial begin
        logic       enPrev;
        logic [8:0] riseVal;
        int         riseCyc;
        int         highLen;
        enPrev  = 1'b0;
        riseVal = '0;
        riseCyc = 0;
        highLen = 0;
        forever begin
            @(negedge s_axi_aclk);
            if (!reset && busy === 1'b0) idleCount++;
            if (frame_done === 1'b1) begin
                fdCount++;
                fdCyc = cyc;
            end
            if (LCD_EN === 1'b1) begin
                if (!enPrev) begin
                    riseVal = {LCD_RS, LCD_DATA};
                    riseCyc = cyc;
                    highLen = 0;
                end
                highLen++;
            end else if (enPrev) begin
                wrLog.push_back(riseVal);
                wrCyc.push_back(riseCyc);
                wrLen.push_back(highLen);
                wrHold.push_back({LCD_RS, LCD_DATA});
            end
            enPrev = (LCD_EN === 1'b1);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called on a falling edge; the strobe is sampled on the following rising edge.
    task automatic applyStimulus(input logic [127:0] d);
        digits       = d;
        digits_valid = 1'b1;
        strobeCyc    = cyc;
        @(negedge s_axi_aclk);
        digits_valid = 1'b0;
    endtask

    task automatic waitWrites(input int n, input int budget);
        for (int i = 0; i < budget && wrLog.size() < n; i++) @(negedge s_axi_aclk);
    endtask

    task automatic waitIdle(input string tag, input int budget);
        for (int i = 0; i < budget && busy !== 1'b0; i++) @(negedge s_axi_aclk);
        checkOutput({tag, " busy low"}, 32'(busy), 32'd0);
    endtask

    function automatic logic [7:0] hexChar(input logic [3:0] v);
        if (v < 4'd10) return 8'h30 + 8'(v);
        return 8'h41 + 8'(v) - 8'd10;
    endfunction

    task automatic pushInit();
        expQ.push_back(9'h038);
        expQ.push_back(9'h038);
        expQ.push_back(9'h038);
        expQ.push_back(9'h00C);
        expQ.push_back(9'h001);
        expQ.push_back(9'h006);
    endtask

    task automatic pushFrame(input logic [127:0] d);
        expQ.push_back(9'h080);
        for (int p = 0; p < 16; p++) expQ.push_back({1'b1, hexChar(d[p*4 +: 4])});
        expQ.push_back(9'h0C0);
        for (int p = 0; p < 16; p++) expQ.push_back({1'b1, hexChar(d[(16+p)*4 +: 4])});
    endtask

    task automatic compareLog(input string tag, input int base);
        checkOutput({tag, " count"}, 32'(wrLog.size() - base), 32'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++) begin
            if (base + i < wrLog.size()) begin
                checkOutput($sformatf("%s w%0d", tag, i), 32'(wrLog[base+i]), 32'(expQ[i]));
                checkOutput($sformatf("%s w%0d hold", tag, i), 32'(wrHold[base+i]), 32'(expQ[i]));
                checkOutput($sformatf("%s w%0d enlen", tag, i), 32'(wrLen[base+i]), 32'(EN_CYC));
            end
        end
    endtask

    function automatic logic [127:0] randDigits();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int          base;
        int          fd0;
        int          ic0;
        logic [127:0] pat;
        logic [127:0] dA;
        logic [127:0] dB;

        hexTable[0]  = '{4'h0, 8'h30};  hexTable[1]  = '{4'h1, 8'h31};
        hexTable[2]  = '{4'h2, 8'h32};  hexTable[3]  = '{4'h3, 8'h33};
        hexTable[4]  = '{4'h4, 8'h34};  hexTable[5]  = '{4'h5, 8'h35};
        hexTable[6]  = '{4'h6, 8'h36};  hexTable[7]  = '{4'h7, 8'h37};
        hexTable[8]  = '{4'h8, 8'h38};  hexTable[9]  = '{4'h9, 8'h39};
        hexTable[10] = '{4'hA, 8'h41};  hexTable[11] = '{4'hB, 8'h42};
        hexTable[12] = '{4'hC, 8'h43};  hexTable[13] = '{4'hD, 8'h44};
        hexTable[14] = '{4'hE, 8'h45};  hexTable[15] = '{4'hF, 8'h46};

        // Reset state and power-up init
        repeat (3) @(negedge s_axi_aclk);
        checkOutput("reset EN", 32'(LCD_EN), 32'd0);
        checkOutput("reset DATA", 32'(LCD_DATA), 32'd0);
        checkOutput("reset RS", 32'(LCD_RS), 32'd0);
        checkOutput("reset ON", 32'(LCD_ON), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset frame_done", 32'(frame_done), 32'd0);
        checkOutput("RW", 32'(LCD_RW), 32'd0);
        base = wrLog.size();
        reset = 1'b0;
        @(negedge s_axi_aclk);
        checkOutput("ON after release", 32'(LCD_ON), 32'd1);
        checkOutput("busy after release", 32'(busy), 32'd1);
        waitWrites(base + 6, 400);
        expQ.delete();
        pushInit();
        compareLog("init", base);
        if (wrLog.size() >= base + 6) begin
            checkOutput("first EN rise cycle", 32'(wrCyc[base]), 32'(PWRUP_CYC + 1));
            for (int i = 1; i < 6; i++)
                checkOutput($sformatf("init gap%0d", i), 32'(wrCyc[base+i] - wrCyc[base+i-1]),
                            32'((i == 5) ? (1 + EN_CYC + CLR_CYC) : WR_CYC));
        end
        waitIdle("init", 100);
        repeat (100) @(negedge s_axi_aclk);
        checkOutput("idle bus quiet", 32'(wrLog.size() - base), 32'd6);

        // Table-driven frame: digit r = r mod 16
        pat = '0;
        for (int r = 0; r < 32; r++) pat[r*4 +: 4] = hexTable[r % 16].v;
        base = wrLog.size();
        fd0  = fdCount;
        applyStimulus(pat);
        waitWrites(base + 34, 600);
        checkOutput("tbl count", 32'(wrLog.size() - base), 32'd34);
        if (wrLog.size() >= base + 34) begin
            checkOutput("tbl addr1", 32'(wrLog[base]), 32'h080);
            checkOutput("tbl addr2", 32'(wrLog[base+17]), 32'h0C0);
            for (int p = 0; p < 16; p++) begin
                checkOutput($sformatf("tbl L1 p%0d", p), 32'(wrLog[base+1+p]), {23'd0, 1'b1, hexTable[p].ch});
                checkOutput($sformatf("tbl L2 p%0d", p), 32'(wrLog[base+18+p]), {23'd0, 1'b1, hexTable[p].ch});
            end
            checkOutput("idle to addr1 latency", 32'(wrCyc[base]), 32'(strobeCyc + 3));
        end
        waitIdle("tbl", 50);
        checkOutput("tbl frame_done once", 32'(fdCount - fd0), 32'd1);
        if (wrLog.size() >= base + 1)
            checkOutput("frame length", 32'(fdCyc - wrCyc[base] + 2), 32'(34 * WR_CYC));

        // Strobe mid LINE1: current frame must not tear
        base = wrLog.size();
        fd0  = fdCount;
        applyStimulus('0);
        waitWrites(base + 1, 100);
        ic0 = idleCount;
        waitWrites(base + 5, 200);
        @(negedge s_axi_aclk);
        applyStimulus({128{1'b1}});
        waitWrites(base + 68, 1200);
        checkOutput("no idle between frames", 32'(idleCount - ic0), 32'd0);
        expQ.delete();
        pushFrame('0);
        pushFrame({128{1'b1}});
        compareLog("tear", base);
        if (wrLog.size() >= base + 35)
            checkOutput("tear b2b gap", 32'(wrCyc[base+34] - wrCyc[base+33]), 32'(WR_CYC));
        waitIdle("tear", 50);
        checkOutput("tear frame_done", 32'(fdCount - fd0), 32'd2);

        // Strobe during PWRUP is held until init completes
        reset = 1'b1;
        repeat (2) @(negedge s_axi_aclk);
        base  = wrLog.size();
        reset = 1'b0;
        for (int i = 0; i < 20 && cyc < 5; i++) @(negedge s_axi_aclk);
        dA = randDigits();
        applyStimulus(dA);
        waitWrites(base + 40, 1000);
        expQ.delete();
        pushInit();
        pushFrame(dA);
        compareLog("early", base);
        if (wrLog.size() >= base + 7) begin
            checkOutput("early first rise", 32'(wrCyc[base]), 32'(PWRUP_CYC + 1));
            checkOutput("early init-frame gap", 32'(wrCyc[base+6] - wrCyc[base+5]), 32'(WR_CYC));
        end
        waitIdle("early", 50);

        // Strobe exactly on the frame_done cycle
        base = wrLog.size();
        dA = randDigits();
        dB = randDigits();
        applyStimulus(dA);
        for (int i = 0; i < 600 && frame_done !== 1'b1; i++) @(negedge s_axi_aclk);
        checkOutput("fd seen", 32'(frame_done), 32'd1);
        applyStimulus(dB);
        waitWrites(base + 68, 700);
        expQ.delete();
        pushFrame(dA);
        pushFrame(dB);
        compareLog("fdstrobe", base);
        if (wrLog.size() >= base + 35)
            checkOutput("fdstrobe b2b gap", 32'(wrCyc[base+34] - wrCyc[base+33]), 32'(WR_CYC));
        waitIdle("fdstrobe", 50);

        // Reset while EN is high in LINE2
        base = wrLog.size();
        applyStimulus(randDigits());
        for (int i = 0; i < 600 && !(wrLog.size() >= base + 19 && LCD_EN === 1'b1); i++)
            @(negedge s_axi_aclk);
        checkOutput("mid LINE2 EN high", 32'(LCD_EN), 32'd1);
        reset = 1'b1;
        @(negedge s_axi_aclk);
        checkOutput("rst EN drop", 32'(LCD_EN), 32'd0);
        checkOutput("rst DATA clear", 32'(LCD_DATA), 32'd0);
        checkOutput("rst busy clear", 32'(busy), 32'd0);
        @(negedge s_axi_aclk);
        base  = wrLog.size();
        reset = 1'b0;
        waitWrites(base + 6, 400);
        expQ.delete();
        pushInit();
        compareLog("reinit", base);
        waitIdle("reinit", 100);
        repeat (100) @(negedge s_axi_aclk);
        checkOutput("reinit quiet", 32'(wrLog.size() - base), 32'd6);

        // Randomised frames against the reference model
        for (int k = 0; k < 3; k++) begin
            base = wrLog.size();
            dA = randDigits();
            applyStimulus(dA);
            waitWrites(base + 34, 600);
            expQ.delete();
            pushFrame(dA);
            compareLog($sformatf("rand%0d", k), base);
            waitIdle($sformatf("rand%0d", k), 50);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
